// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
//   AXI4 burst slave in front of a word-addressed RAM. The write channel
//   (AW/W/B) and the read channel (AR/R) run independent state machines and
//   each accepts one transaction at a time. Bursts that carry an unsupported
//   size, the reserved burst type or an illegal WRAP length still run their
//   full beat count so the master never stalls, but they answer SLVERR.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting write beats into the RAM
// W_RESP | BVALID high, holding BID/BRESP until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting registered read beats
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW*  : write address (id, byte address, len, size, burst)
//   S_AXI_W*   : write data with byte strobes and WLAST
//   S_AXI_B*   : write response
//   S_AXI_AR*  : read address
//   S_AXI_R*   : read data, response and RLAST
// ---------------------------------------------------------------------------
module axi_mem_responder #(
   parameter int AXI_ID_WIDTH   = 1,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MEM_AW         = 8
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                  S_AXI_AWLEN,
   input  logic [2:0]                  S_AXI_AWSIZE,
   input  logic [1:0]                  S_AXI_AWBURST,
   input  logic                        S_AXI_AWVALID,
   output logic                        S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                        S_AXI_WLAST,
   input  logic                        S_AXI_WVALID,
   output logic                        S_AXI_WREADY,
   output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                  S_AXI_BRESP,
   output logic                        S_AXI_BVALID,
   input  logic                        S_AXI_BREADY,
   input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                  S_AXI_ARLEN,
   input  logic [2:0]                  S_AXI_ARSIZE,
   input  logic [1:0]                  S_AXI_ARBURST,
   input  logic                        S_AXI_ARVALID,
   output logic                        S_AXI_ARREADY,
   output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                  S_AXI_RRESP,
   output logic                        S_AXI_RLAST,
   output logic                        S_AXI_RVALID,
   input  logic                        S_AXI_RREADY
);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam int         NUM_LANES   = AXI_DATA_WIDTH / 8;
   localparam int         MEM_DEPTH   = 1 << MEM_AW;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
      logic wrap_ok;
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
   endfunction

   // Bad burst encodings are still sequenced, as INCR.
   function automatic logic [1:0] burst_seq(input logic [1:0] burst, input logic [7:0] len);
      return burst_bad(burst, len) ? BURST_INCR : burst;
   endfunction

   // WRAP keeps the bits above the (len+1)*4 byte block and wraps the bits
   // inside it; legal WRAP lengths make that block a power of two.
   function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
      input logic [AXI_ADDR_WIDTH-1:0] addr,
      input logic [7:0]                len,
      input logic [1:0]                burst
   );
      logic [AXI_ADDR_WIDTH-1:0] mask;
      logic [AXI_ADDR_WIDTH-1:0] inc;
      mask = AXI_ADDR_WIDTH'({len, 2'b11});
      inc  = addr + AXI_ADDR_WIDTH'(4);
      case (burst)
         BURST_FIXED: return addr;
         BURST_WRAP:  return (addr & ~mask) | (inc & mask);
         default:     return inc;
      endcase
   endfunction

   // write channel state
   w_state_e                  w_state_q, w_state_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      bvalid_q, bvalid_d;
   logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [7:0]                wlen_q, wlen_d;
   logic [7:0]                wbeat_q, wbeat_d;
   logic [1:0]                wburst_q, wburst_d;
   logic                      werr_q, werr_d;
   logic                      wsupp_q, wsupp_d;

   // read channel state
   r_state_e                  r_state_q, r_state_d;
   logic                      arready_q, arready_d;
   logic                      rvalid_q, rvalid_d;
   logic                      rlast_q, rlast_d;
   logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
   logic [1:0]                rresp_q, rresp_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [7:0]                rlen_q, rlen_d;
   logic [7:0]                rbeat_q, rbeat_d;
   logic [1:0]                rburst_q, rburst_d;
   logic                      rerr_q, rerr_d;
   logic                      rzero_q, rzero_d;

   // RAM
   logic [AXI_DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];
   logic                      mem_we;
   logic [MEM_AW-1:0]         mem_widx;
   logic [MEM_AW-1:0]         rd_idx;
   logic [AXI_DATA_WIDTH-1:0] rd_word;

   assign mem_widx = waddr_q[MEM_AW+1:2];
   // In idle the read index follows ARADDR so beat 0 is registered on the
   // handshake edge; afterwards it follows the next-beat address.
   assign rd_idx   = (r_state_q == R_IDLE) ? S_AXI_ARADDR[MEM_AW+1:2] : raddr_q[MEM_AW+1:2];
   assign rd_word  = mem_q[rd_idx];

   // RAM has no reset so contents survive S_AXI_ARESETN. A read in the same
   // cycle as a write to that word registers the old word.
   always_ff @(posedge S_AXI_ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (S_AXI_WSTRB[i]) begin
               mem_q[mem_widx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
         end
      end
   end

   // -------------------------------------------------------------- write FSM
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wbeat_d   = wbeat_q;
      wburst_d  = wburst_q;
      werr_d    = werr_q;
      wsupp_d   = wsupp_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (S_AXI_AWVALID && awready_q) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               bid_d     = S_AXI_AWID;
               waddr_d   = S_AXI_AWADDR;
               wlen_d    = S_AXI_AWLEN;
               wbeat_d   = 8'd0;
               wburst_d  = burst_seq(S_AXI_AWBURST, S_AXI_AWLEN);
               wsupp_d   = (S_AXI_AWSIZE != SIZE_WORD);
               werr_d    = (S_AXI_AWSIZE != SIZE_WORD) || burst_bad(S_AXI_AWBURST, S_AXI_AWLEN);
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (S_AXI_WVALID && wready_q) begin
               mem_we  = !wsupp_q;
               waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
               wbeat_d = wbeat_q + 8'd1;
               // An early WLAST ends the burst; a missing WLAST on the
               // final beat ends it too. Both are reported as SLVERR.
               if (S_AXI_WLAST || (wbeat_q == wlen_q)) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = (werr_q || !(S_AXI_WLAST && (wbeat_q == wlen_q))) ? RESP_SLVERR
                                                                               : RESP_OKAY;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
            w_state_d = W_IDLE;
         end
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= RESP_OKAY;
         waddr_q   <= '0;
         wlen_q    <= 8'd0;
         wbeat_q   <= 8'd0;
         wburst_q  <= BURST_INCR;
         werr_q    <= 1'b0;
         wsupp_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wburst_q  <= wburst_d;
         werr_q    <= werr_d;
         wsupp_q   <= wsupp_d;
      end
   end

   // --------------------------------------------------------------- read FSM
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rburst_d  = rburst_q;
      rerr_d    = rerr_q;
      rzero_d   = rzero_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (S_AXI_ARVALID && arready_q) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rid_d     = S_AXI_ARID;
               rlen_d    = S_AXI_ARLEN;
               rbeat_d   = 8'd0;
               rburst_d  = burst_seq(S_AXI_ARBURST, S_AXI_ARLEN);
               rzero_d   = (S_AXI_ARSIZE != SIZE_WORD);
               rerr_d    = (S_AXI_ARSIZE != SIZE_WORD) || burst_bad(S_AXI_ARBURST, S_AXI_ARLEN);
               rresp_d   = rerr_d ? RESP_SLVERR : RESP_OKAY;
               rdata_d   = rzero_d ? '0 : rd_word;
               rlast_d   = (S_AXI_ARLEN == 8'd0);
               raddr_d   = next_addr(S_AXI_ARADDR, S_AXI_ARLEN, rburst_d);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && S_AXI_RREADY) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  rdata_d = rzero_q ? '0 : rd_word;
                  rbeat_d = rbeat_q + 8'd1;
                  rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                  raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
               end
            end
         end
         default: begin
            arready_d = 1'b0;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         raddr_q   <= '0;
         rlen_q    <= 8'd0;
         rbeat_q   <= 8'd0;
         rburst_q  <= BURST_INCR;
         rerr_q    <= 1'b0;
         rzero_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rburst_q  <= rburst_d;
         rerr_q    <= rerr_d;
         rzero_q   <= rzero_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BID     = bid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RID     = rid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: drives AXI bursts, keeps a word-array model
// of the RAM and compares responses and read data against it.
module tb_axi_mem_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        aw_id, aw_valid, w_last, w_valid, b_ready, ar_id, ar_valid, r_ready;
   logic [31:0] aw_addr, ar_addr, w_data;
   logic [7:0]  aw_len, ar_len;
   logic [2:0]  aw_size, ar_size;
   logic [1:0]  aw_burst, ar_burst;
   logic [3:0]  w_strb;
   logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, b_id, r_id;
   logic [1:0]  b_resp, r_resp;
   logic [31:0] r_data;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWID(aw_id), .S_AXI_AWADDR(aw_addr), .S_AXI_AWLEN(aw_len), .S_AXI_AWSIZE(aw_size),
      .S_AXI_AWBURST(aw_burst), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready),
      .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WLAST(w_last), .S_AXI_WVALID(w_valid),
      .S_AXI_WREADY(w_ready), .S_AXI_BID(b_id), .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid),
      .S_AXI_BREADY(b_ready), .S_AXI_ARID(ar_id), .S_AXI_ARADDR(ar_addr), .S_AXI_ARLEN(ar_len),
      .S_AXI_ARSIZE(ar_size), .S_AXI_ARBURST(ar_burst), .S_AXI_ARVALID(ar_valid),
      .S_AXI_ARREADY(ar_ready), .S_AXI_RID(r_id), .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp),
      .S_AXI_RLAST(r_last), .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [256];
   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   logic [31:0] rd_q [$];
   logic [1:0]  rr_q [$];
   logic        rl_q [$];
   logic        ri_q [$];

   // ---------------------------------------------------------- reference model
   function automatic bit m_size_err(input logic [2:0] size);
      return size != 3'b010;
   endfunction

   function automatic bit m_wrap_ok(input logic [7:0] len);
      return len == 1 || len == 3 || len == 7 || len == 15;
   endfunction

   function automatic bit m_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
      return m_size_err(size) || burst == 2'b11 || (burst == 2'b10 && !m_wrap_ok(len));
   endfunction

   function automatic logic [31:0] m_addr(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [1:0] burst, input int i);
      longint unsigned blk, base;
      if (burst == 2'b00) return addr;
      if (burst == 2'b10 && m_wrap_ok(len)) begin
         blk  = (longint'(len) + 1) * 4;
         base = addr - (addr % blk);
         return 32'(base + ((addr - base + 4 * i) % blk));
      end
      return addr + 32'(4 * i);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a / 4) % 256);
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst, input int n);
      int k;
      if (m_size_err(size)) return;
      for (int i = 0; i < n; i++) begin
         k = m_idx(m_addr(addr, len, burst, i));
         for (int l = 0; l < 4; l++)
            if (ws[i][l]) model[k][8*l +: 8] = wd[i][8*l +: 8];
      end
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int i);
      if (m_size_err(size)) return 32'h0;
      return model[m_idx(m_addr(addr, len, burst, i))];
   endfunction

   // ------------------------------------------------------------ bus drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // last_at: beat carrying WLAST (== len normal, < len early, -1 none)
   task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at,
                            input bit gaps, output logic [1:0] resp, output logic bid_o);
      int cnt, n;
      bit hs;
      resp = 2'bxx;
      bid_o = 1'bx;
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
      hs = 0; cnt = 0;
      while (!hs && cnt < 1000) begin hs = aw_ready; tick(); cnt++; end
      aw_valid = 1'b0;
      if (!hs) begin
         checks++; errors++; $display("FAIL aw_timeout got no AWREADY want AWREADY"); return;
      end
      n = (last_at >= 0 && last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
      for (int b = 0; b < n; b++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         w_data = wd[b]; w_strb = ws[b]; w_last = (b == last_at); w_valid = 1'b1;
         hs = 0; cnt = 0;
         while (!hs && cnt < 1000) begin hs = w_ready; tick(); cnt++; end
         w_valid = 1'b0; w_last = 1'b0;
         if (!hs) begin
            checks++; errors++; $display("FAIL w_timeout beat %0d got no WREADY want WREADY", b); return;
         end
      end
      b_ready = 1'b1; hs = 0; cnt = 0;
      while (!hs && cnt < 1000) begin
         if (b_valid) begin hs = 1; resp = b_resp; bid_o = b_id; end
         tick(); cnt++;
      end
      b_ready = 1'b0;
      if (!hs) begin checks++; errors++; $display("FAIL b_timeout got no BVALID want BVALID"); end
      model_write(addr, len, size, burst, n);
   endtask

   task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
      int cnt;
      bit hs, done, held, rdy;
      logic [31:0] hold_d;
      logic hold_l;
      rd_q.delete(); rr_q.delete(); rl_q.delete(); ri_q.delete();
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
      hs = 0; cnt = 0;
      while (!hs && cnt < 1000) begin hs = ar_ready; tick(); cnt++; end
      ar_valid = 1'b0;
      if (!hs) begin
         checks++; errors++; $display("FAIL ar_timeout got no ARREADY want ARREADY"); return;
      end
      done = 0; held = 0; cnt = 0; hold_d = '0; hold_l = 1'b0;
      while (!done && cnt < 2000) begin
         rdy = stall ? ((cnt % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
         r_ready = rdy;
         if (held) begin
            checks++;
            if (r_valid !== 1'b1 || r_data !== hold_d || r_last !== hold_l) begin
               errors++;
               $display("FAIL r_stall_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        r_valid, r_data, r_last, hold_d, hold_l);
            end
         end
         held = 0;
         if (r_valid && rdy) begin
            rd_q.push_back(r_data); rr_q.push_back(r_resp); rl_q.push_back(r_last); ri_q.push_back(r_id);
            if (r_last) done = 1;
         end else if (r_valid) begin
            hold_d = r_data; hold_l = r_last; held = 1;
         end
         tick(); cnt++;
      end
      r_ready = 1'b0;
      if (!done) begin checks++; errors++; $display("FAIL r_timeout got no RLAST want RLAST"); end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      logic [1:0] resp;
      logic bid_o;
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'b010; aw_burst = 2'b01; aw_valid = 0;
      w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'b010; ar_burst = 2'b01; ar_valid = 0; r_ready = 0;
      rst_n = 1'b0;
      repeat (5) tick();
      checks++;
      if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 000000",
                             {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last});
      end
      checks++;
      if ({b_resp, r_resp, b_id, r_id, r_data} !== 38'b0) begin
         errors++; $display("FAIL reset_data got %h want 0", {b_resp, r_resp, b_id, r_id, r_data});
      end
      rst_n = 1'b1;
      checks++;
      if (aw_ready !== 1'b0) begin errors++; $display("FAIL awready_release got %b want 0", aw_ready); end
      tick();
      checks++;
      if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_reset got aw=%b ar=%b want 1 1", aw_ready, ar_ready);
      end
      // Fill the whole RAM so the model is fully known.
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(0, 32'h0, 8'd255, 3'b010, 2'b01, 255, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL init_bresp got %b want 00", resp); end
   endtask

   task automatic test_single();
      logic [1:0] resp;
      logic bid_o;
      wd[0] = 32'h03; ws[0] = 4'hF;
      axi_write(1, 32'h0, 8'd0, 3'b010, 2'b01, 0, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b00 || bid_o !== 1'b1) begin
         errors++; $display("FAIL single_b got resp=%b id=%b want resp=00 id=1", resp, bid_o);
      end
      axi_read(1, 32'h0, 8'd0, 3'b010, 2'b01, 0);
      checks++;
      if (rd_q.size() != 1 || rd_q[0] !== 32'h03 || rl_q[0] !== 1'b1 || ri_q[0] !== 1'b1 || rr_q[0] !== 2'b00) begin
         errors++; $display("FAIL single_r got n=%0d d=%h want n=1 d=00000003 last=1 id=1 okay",
                            rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
      end
   endtask

   task automatic test_incr();
      logic [1:0] resp;
      logic bid_o;
      for (int b = 0; b < 32; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      wd[0] = 32'h64343962; wd[31] = 32'h00020000;
      axi_write(0, 32'h40, 8'd31, 3'b010, 2'b01, 31, 1, resp, bid_o);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", resp); end
      axi_read(0, 32'h40, 8'd31, 3'b010, 2'b01, 0);
      checks++;
      if (rd_q.size() != 32) begin errors++; $display("FAIL incr_count got %0d want 32", rd_q.size()); end
      for (int i = 0; i < rd_q.size(); i++) begin
         checks++;
         if (rd_q[i] !== wd[i] || rl_q[i] !== (i == 31) || rr_q[i] !== 2'b00) begin
            errors++; $display("FAIL incr_beat%0d got d=%h l=%b want d=%h l=%b", i, rd_q[i], rl_q[i], wd[i], i == 31);
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] resp;
      logic bid_o;
      logic [31:0] exp4 [4];
      for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(0, 32'h18, 8'd3, 3'b010, 2'b10, 3, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp got %b want 00", resp); end
      exp4[0] = wd[2]; exp4[1] = wd[3]; exp4[2] = wd[0]; exp4[3] = wd[1];
      axi_read(0, 32'h10, 8'd3, 3'b010, 2'b01, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== exp4[i]) begin
            errors++; $display("FAIL wrap_incr_read%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, exp4[i]);
         end
      end
      axi_read(0, 32'h18, 8'd3, 3'b010, 2'b10, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== wd[i]) begin
            errors++; $display("FAIL wrap_wrap_read%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, wd[i]);
         end
      end
   endtask

   task automatic test_fixed_strb();
      logic [1:0] resp;
      logic bid_o;
      for (int b = 0; b < 4; b++) begin wd[b] = b + 1; ws[b] = 4'hF; end
      axi_write(0, 32'h80, 8'd3, 3'b010, 2'b00, 3, 0, resp, bid_o);
      axi_read(0, 32'h80, 8'd0, 3'b010, 2'b01, 0);
      checks++;
      if (resp !== 2'b00 || rd_q.size() != 1 || rd_q[0] !== 32'd4) begin
         errors++; $display("FAIL fixed got resp=%b d=%h want resp=00 d=00000004", resp, (rd_q.size() > 0) ? rd_q[0] : 32'hx);
      end
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
      axi_write(0, 32'h84, 8'd0, 3'b010, 2'b01, 0, 0, resp, bid_o);
      wd[0] = 32'h0; ws[0] = 4'b0011;
      axi_write(0, 32'h84, 8'd0, 3'b010, 2'b01, 0, 0, resp, bid_o);
      axi_read(0, 32'h84, 8'd0, 3'b010, 2'b01, 0);
      checks++;
      if (rd_q.size() != 1 || rd_q[0] !== 32'hFFFF0000) begin
         errors++; $display("FAIL strobe got %h want FFFF0000", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp;
      logic bid_o;
      axi_read(1, 32'h40, 8'd7, 3'b010, 2'b01, 1);
      checks++;
      if (rd_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d want 8", rd_q.size()); end
      for (int i = 0; i < rd_q.size(); i++) begin
         checks++;
         if (rd_q[i] !== m_rdata(32'h40, 7, 3'b010, 2'b01, i) || rl_q[i] !== (i == 7)) begin
            errors++; $display("FAIL stall_beat%0d got d=%h l=%b want d=%h l=%b", i, rd_q[i], rl_q[i],
                               m_rdata(32'h40, 7, 3'b010, 2'b01, i), i == 7);
         end
      end
      for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(0, 32'h40, 8'd1, 3'b001, 2'b01, 1, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL size_bresp got %b want 10", resp); end
      axi_read(0, 32'h40, 8'd1, 3'b010, 2'b01, 0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== model[16 + i]) begin
            errors++; $display("FAIL size_ram_kept%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, model[16 + i]);
         end
      end
      for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(0, 32'h100, 8'd3, 3'b010, 2'b01, -1, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL nolast_bresp got %b want 10", resp); end
      axi_write(0, 32'h120, 8'd7, 3'b010, 2'b01, 2, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL earlylast_bresp got %b want 10", resp); end
      // the burst after an early WLAST must start cleanly
      axi_write(1, 32'h140, 8'd1, 3'b010, 2'b01, 1, 0, resp, bid_o);
      checks++;
      if (resp !== 2'b00 || bid_o !== 1'b1) begin
         errors++; $display("FAIL after_early_b got resp=%b id=%b want 00 1", resp, bid_o);
      end
      axi_read(0, 32'h40, 8'd3, 3'b010, 2'b11, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= rd_q.size() || rr_q[i] !== 2'b10 || rd_q[i] !== m_rdata(32'h40, 3, 3'b010, 2'b11, i)) begin
            errors++; $display("FAIL rsvd_read%0d got resp=%b d=%h want resp=10 d=%h", i,
                               (i < rr_q.size()) ? rr_q[i] : 2'bx, (i < rd_q.size()) ? rd_q[i] : 32'hx,
                               m_rdata(32'h40, 3, 3'b010, 2'b11, i));
         end
      end
      axi_read(0, 32'h40, 8'd2, 3'b000, 2'b01, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= rd_q.size() || rr_q[i] !== 2'b10 || rd_q[i] !== 32'h0) begin
            errors++; $display("FAIL size_read%0d got resp=%b d=%h want resp=10 d=0", i,
                               (i < rr_q.size()) ? rr_q[i] : 2'bx, (i < rd_q.size()) ? rd_q[i] : 32'hx);
         end
      end
   endtask

   task automatic test_concurrent();
      logic [1:0] resp;
      logic bid_o;
      for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      fork
         axi_write(1, 32'h200, 8'd7, 3'b010, 2'b01, 7, 0, resp, bid_o);
         axi_read(0, 32'h40, 8'd7, 3'b010, 2'b01, 0);
      join
      checks++;
      if (resp !== 2'b00 || bid_o !== 1'b1) begin errors++; $display("FAIL conc_b got %b %b want 00 1", resp, bid_o); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== model[16 + i]) begin
            errors++; $display("FAIL conc_r%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, model[16 + i]);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] resp, exp_resp;
      logic bid_o;
      logic [31:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      int last_at, sel;
      for (int t = 0; t < 30; t++) begin
         addr  = $urandom & 32'hFFFF_FFFC;
         sel   = $urandom_range(0, 9);
         len   = (sel < 3) ? 8'(2 ** $urandom_range(1, 4) - 1) : 8'($urandom_range(0, 15));
         burst = (sel < 3) ? 2'b10 : 2'($urandom_range(0, 3));
         size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
         sel   = $urandom_range(0, 9);
         last_at = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(0, len)) : int'(len);
         for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15)); end
         exp_resp = (m_err(size, burst, len) || last_at != int'(len)) ? 2'b10 : 2'b00;
         axi_write(1'($urandom), addr, len, size, burst, last_at, 1, resp, bid_o);
         checks++;
         if (resp !== exp_resp) begin
            errors++; $display("FAIL rand%0d_bresp got %b want %b", t, resp, exp_resp);
         end
         axi_read(1'(t), addr, len, size, burst, 1'($urandom));
         checks++;
         if (rd_q.size() != int'(len) + 1) begin
            errors++; $display("FAIL rand%0d_rcount got %0d want %0d", t, rd_q.size(), int'(len) + 1);
         end
         for (int i = 0; i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== m_rdata(addr, len, size, burst, i) || rl_q[i] !== (i == int'(len)) ||
                rr_q[i] !== (m_err(size, burst, len) ? 2'b10 : 2'b00) || ri_q[i] !== 1'(t)) begin
               errors++; $display("FAIL rand%0d_beat%0d got d=%h l=%b r=%b want d=%h", t, i, rd_q[i], rl_q[i],
                                  rr_q[i], m_rdata(addr, len, size, burst, i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      ar_id = 0; ar_addr = 32'h40; ar_len = 8'd15; ar_size = 3'b010; ar_burst = 2'b01; ar_valid = 1'b1;
      cnt = 0;
      while (!ar_ready && cnt < 50) begin tick(); cnt++; end
      tick();
      ar_valid = 1'b0; r_ready = 1'b1;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({r_valid, r_last, ar_ready, aw_ready} !== 4'b0) begin
         errors++; $display("FAIL rst_mid_read got %b want 0000", {r_valid, r_last, ar_ready, aw_ready});
      end
      r_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      aw_id = 0; aw_addr = 32'h300; aw_len = 8'd7; aw_size = 3'b010; aw_burst = 2'b01; aw_valid = 1'b1;
      cnt = 0;
      while (!aw_ready && cnt < 50) begin tick(); cnt++; end
      tick();
      aw_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         w_data = $urandom; w_strb = 4'hF; w_valid = 1'b1;
         cnt = 0;
         while (!w_ready && cnt < 50) begin tick(); cnt++; end
         tick();
         if (cnt < 50) model[m_idx(32'h300 + 32'(4 * b))] = w_data;
      end
      checks++;
      if (cnt >= 50) begin errors++; $display("FAIL rst_mid_w_timeout got no WREADY want WREADY"); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({aw_ready, w_ready, b_valid, ar_ready, r_valid} !== 5'b0) begin
         errors++; $display("FAIL rst_mid_write got %b want 00000", {aw_ready, w_ready, b_valid, ar_ready, r_valid});
      end
      w_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0) begin
         errors++; $display("FAIL rst_mid_release got aw=%b ar=%b w=%b want 1 1 0", aw_ready, ar_ready, w_ready);
      end
      axi_read(0, 32'h300, 8'd7, 3'b010, 2'b01, 0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== model[192 + i]) begin
            errors++; $display("FAIL rst_mid_wram%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, model[192 + i]);
         end
      end
      axi_read(0, 32'h40, 8'd15, 3'b010, 2'b01, 0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i >= rd_q.size() || rd_q[i] !== model[16 + i]) begin
            errors++; $display("FAIL rst_mid_rram%0d got %h want %h", i, (i < rd_q.size()) ? rd_q[i] : 32'hx, model[16 + i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr();
      test_wrap();
      test_fixed_strb();
      test_errors();
      test_concurrent();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
